// File: rtl/mdr_fifo_pkg.sv
// Shared definitions for the memory data register / write-buffer block.
package mdr_fifo_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_e;

endpackage

// File: rtl/mdr_fifo_if.sv
// Control and status handshake between the host/memory side and mdr_fifo.
interface mdr_fifo_if;

    logic nLw;
    logic nLr;
    logic Ew;
    logic mem_ack;
    logic mem_req;
    logic mem_we;
    logic full;
    logic empty;
    logic rd_valid;
    logic ovf;

    modport master (
        output nLw, nLr, Ew, mem_ack,
        input  mem_req, mem_we, full, empty, rd_valid, ovf
    );

    modport slave (
        input  nLw, nLr, Ew, mem_ack,
        output mem_req, mem_we, full, empty, rd_valid, ovf
    );

endinterface

// File: rtl/mdr_fifo_buf.sv
// Synchronous FIFO storage with occupancy count; pushes into a full buffer are dropped.
module mdr_fifo_buf import mdr_fifo_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mdr_fifo.sv
// Memory data register: buffered writes to memory plus a single outstanding read,
// sequenced by a WR/RD FSM; drives WBUS and the memory data bus as tristates.
module mdr_fifo import mdr_fifo_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             nCLR,
    mdr_fifo_if.slave        bus,
    inout  wire [WIDTH-1:0]  WBUS,
    inout  wire [WIDTH-1:0]  data
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] head;
    logic [CW-1:0]    count;
    logic             full, empty;
    logic             push, push_ok, pop, rd_req;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rd_reg_q, rd_reg_d;
    logic             pend_q, pend_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_q, ovf_d;
    logic             mem_req_q, mem_we_q;

    mdr_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
        .clk   (CLK),
        .rst_n (nCLR),
        .push  (push),
        .pop   (pop),
        .din   (WBUS),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign push    = ~bus.nLw;
    assign push_ok = push & ~full;
    assign pop     = (state_q == WR) & bus.mem_ack;
    assign rd_req  = ~bus.nLr & ~pend_q & (state_q != RD);

    assign WBUS = bus.Ew ? rd_reg_q : 'z;
    assign data = (state_q == WR) ? head : 'z;

    always_comb begin
        state_d    = state_q;
        rd_reg_d   = rd_reg_q;
        pend_d     = pend_q;
        rd_valid_d = rd_valid_q;
        ovf_d      = ovf_q | (push & full);
        if (rd_req) begin
            pend_d     = 1'b1;
            rd_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (!empty)      state_d = WR;
                else if (pend_q) state_d = RD;
            end
            // Drain every buffered word before a pending read is served.
            WR: if (bus.mem_ack) begin
                if ((count > CW'(1)) || push_ok) state_d = WR;
                else if (pend_d)                 state_d = RD;
                else                             state_d = IDLE;
            end
            RD: if (bus.mem_ack) begin
                rd_reg_d   = data;
                rd_valid_d = 1'b1;
                pend_d     = 1'b0;
                state_d    = (!empty || push_ok) ? WR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q    <= IDLE;
            rd_reg_q   <= '0;
            pend_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_reg_q   <= rd_reg_d;
            pend_q     <= pend_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            mem_req_q  <= (state_d != IDLE);
            mem_we_q   <= (state_d == WR);
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_mdr_fifo.sv
// Directed bench for mdr_fifo: default 8x4 instance plus a 16x2 instance for wrap checks.
module tb_mdr_fifo;

    logic CLK;
    logic nCLR;

    mdr_fifo_if bif();
    mdr_fifo_if bif2();

    wire  [7:0]  WBUS, data;
    logic [7:0]  wbus_drv, data_drv;
    logic        wbus_oe, data_oe;
    wire  [15:0] WBUS2, data2;
    logic [15:0] wbus2_drv;
    logic        wbus2_oe;

    assign WBUS  = wbus_oe  ? wbus_drv  : 'z;
    assign data  = data_oe  ? data_drv  : 'z;
    assign WBUS2 = wbus2_oe ? wbus2_drv : 'z;

    mdr_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK(CLK), .nCLR(nCLR), .bus(bif.slave), .WBUS(WBUS), .data(data)
    );

    mdr_fifo #(.WIDTH(16), .DEPTH(2)) dut2 (
        .CLK(CLK), .nCLR(nCLR), .bus(bif2.slave), .WBUS(WBUS2), .data(data2)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        wbus_drv = v;
        wbus_oe  = 1'b1;
        bif.nLw  = 1'b0;
        tick();
        bif.nLw  = 1'b1;
        wbus_oe  = 1'b0;
    endtask

    task automatic push2(input logic [15:0] v);
        wbus2_drv = v;
        wbus2_oe  = 1'b1;
        bif2.nLw  = 1'b0;
        tick();
        bif2.nLw  = 1'b1;
        wbus2_oe  = 1'b0;
    endtask

    logic [7:0]  exp8 [4];
    logic [15:0] vals [6];
    logic [15:0] q2 [$];

    initial begin
        exp8 = '{8'h11, 8'h22, 8'h33, 8'h44};
        vals = '{16'hC001, 16'hBEEF, 16'h0F0F, 16'hA55A, 16'h1234, 16'hFFFF};
        nCLR = 1'b0;
        bif.nLw = 1'b1;  bif.nLr = 1'b1;  bif.Ew = 1'b0;  bif.mem_ack = 1'b0;
        bif2.nLw = 1'b1; bif2.nLr = 1'b1; bif2.Ew = 1'b0; bif2.mem_ack = 1'b0;
        wbus_oe = 1'b0; data_oe = 1'b0; wbus2_oe = 1'b0;
        wbus_drv = '0; data_drv = '0; wbus2_drv = '0;

        // Reset state
        #2 bif.Ew = 1'b1;
        #1;
        chk("rst_wbus", WBUS, 32'h00);
        chk("rst_empty", bif.empty, 1);
        chk("rst_full", bif.full, 0);
        chk("rst_mem_req", bif.mem_req, 0);
        chk("rst_rd_valid", bif.rd_valid, 0);
        chk("rst_ovf", bif.ovf, 0);
        bif.Ew = 1'b0;
        tick();
        nCLR = 1'b1;

        // Single write, ack one cycle after mem_req
        push(8'h25);
        chk("w1_empty", bif.empty, 0);
        chk("w1_latency_req", bif.mem_req, 0);
        tick();
        chk("w1_mem_req", bif.mem_req, 1);
        chk("w1_mem_we", bif.mem_we, 1);
        chk("w1_data", data, 32'h25);
        bif.mem_ack = 1'b1;
        tick();
        bif.mem_ack = 1'b0;
        chk("w1_done_req", bif.mem_req, 0);
        chk("w1_done_empty", bif.empty, 1);

        // Overflow: five pushes into a four-deep buffer with memory stalled
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        chk("ovf_full4", bif.full, 1);
        chk("ovf_pre", bif.ovf, 0);
        push(8'h55);
        chk("ovf_set", bif.ovf, 1);
        chk("ovf_full5", bif.full, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_req%0d", i), bif.mem_req, 1);
            chk($sformatf("ovf_we%0d", i), bif.mem_we, 1);
            chk($sformatf("ovf_data%0d", i), data, {24'h0, exp8[i]});
            bif.mem_ack = 1'b1;
            tick();
        end
        bif.mem_ack = 1'b0;
        chk("ovf_drain_req", bif.mem_req, 0);
        chk("ovf_drain_empty", bif.empty, 1);
        chk("ovf_sticky", bif.ovf, 1);

        // Push and read request together: write must complete first
        wbus_drv = 8'h35;
        wbus_oe  = 1'b1;
        bif.nLw  = 1'b0;
        bif.nLr  = 1'b0;
        tick();
        bif.nLw  = 1'b1;
        bif.nLr  = 1'b1;
        wbus_oe  = 1'b0;
        chk("raw_rd_valid0", bif.rd_valid, 0);
        tick();
        chk("raw_wr_we", bif.mem_we, 1);
        chk("raw_wr_data", data, 32'h35);
        bif.mem_ack = 1'b1;
        tick();
        chk("raw_rd_req", bif.mem_req, 1);
        chk("raw_rd_we", bif.mem_we, 0);
        data_drv = 8'h37;
        data_oe  = 1'b1;
        tick();
        bif.mem_ack = 1'b0;
        data_oe  = 1'b0;
        chk("raw_rd_valid", bif.rd_valid, 1);
        chk("raw_idle", bif.mem_req, 0);
        bif.Ew = 1'b1;
        #1;
        chk("raw_wbus", WBUS, 32'h37);
        bif.Ew = 1'b0;

        // Reset in the middle of a write with two entries buffered
        push(8'hA1);
        push(8'hA2);
        chk("mid_req", bif.mem_req, 1);
        chk("mid_we", bif.mem_we, 1);
        bif.Ew = 1'b1;
        #1;
        chk("mid_rd_hold", WBUS, 32'h37);
        bif.Ew = 1'b0;
        nCLR = 1'b0;
        #1;
        chk("mid_rst_req", bif.mem_req, 0);
        chk("mid_rst_we", bif.mem_we, 0);
        chk("mid_rst_empty", bif.empty, 1);
        chk("mid_rst_rd_valid", bif.rd_valid, 0);
        chk("mid_rst_ovf", bif.ovf, 0);
        #1 nCLR = 1'b1;
        bif.mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("mid_quiet%0d", i), bif.mem_req, 0);
        end
        bif.mem_ack = 1'b0;
        push(8'h5A);
        chk("post_rst_push", bif.empty, 0);
        tick();
        chk("post_rst_data", data, 32'h5A);
        bif.mem_ack = 1'b1;
        tick();
        bif.mem_ack = 1'b0;
        chk("post_rst_empty", bif.empty, 1);

        // DEPTH=2 wrap: fill, then pop with a simultaneous push each cycle
        push2(16'hBEEF);
        q2.push_back(16'hBEEF);
        push2(16'hC000);
        q2.push_back(16'hC000);
        chk("d2_full", bif2.full, 1);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("d2_we%0d", k), bif2.mem_we, 1);
            chk($sformatf("d2_full%0d", k), bif2.full, (q2.size() == 2) ? 1 : 0);
            chk($sformatf("d2_data%0d", k), data2, {16'h0, q2[0]});
            bif2.mem_ack = 1'b1;
            if (k > 0) begin
                wbus2_drv = vals[k-1];
                wbus2_oe  = 1'b1;
                bif2.nLw  = 1'b0;
                q2.push_back(vals[k-1]);
            end
            q2.delete(0);
            tick();
            bif2.nLw = 1'b1;
            wbus2_oe = 1'b0;
            chk($sformatf("d2_nonempty%0d", k), bif2.empty, 0);
        end
        chk("d2_last", data2, {16'h0, q2[0]});
        tick();
        bif2.mem_ack = 1'b0;
        chk("d2_empty", bif2.empty, 1);
        chk("d2_idle", bif2.mem_req, 0);
        chk("d2_ovf", bif2.ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdr_fifo.md
MDR_FIFO -- requirements
Module: mdr_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits on both buses.
REQ-002 Parameter DEPTH, default 4: write-buffer entries; power of two, >= 2.
REQ-003 CLK  input  1: single clock; all state updates on posedge.
REQ-004 nCLR  input  1: reset, asynchronous, active-low.
REQ-005 WBUS  inout  WIDTH: system bus; sampled on push, driven on bus read.
REQ-006 data  inout  WIDTH: memory data bus; driven during write, sampled during read.
REQ-007 nLw  input  1: active-low; push WBUS into write buffer at posedge.
REQ-008 nLr  input  1: active-low; request one memory read at posedge.
REQ-009 Ew  input  1: active-high; drive read register onto WBUS.
REQ-010 mem_req  output  1: memory transaction in progress.
REQ-011 mem_we  output  1: 1 = write, 0 = read; meaningful only while mem_req = 1.
REQ-012 mem_ack  input  1: memory completes current transaction at posedge where mem_req & mem_ack.
REQ-013 full, empty  output  1 each: write-buffer status.
REQ-014 rd_valid  output  1: read register holds fresh memory data.
REQ-015 ovf  output  1: sticky overflow flag.

Function
REQ-016 WBUS SHALL be driven with rd_reg when Ew = 1, else high-impedance (combinational).
REQ-017 data SHALL be driven with the buffer head when state = WR, else high-impedance.
REQ-018 Write buffer SHALL be FIFO order, count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-019 Push with full = 1 SHALL drop the word and set ovf; ovf clears only on reset.
REQ-020 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-021 FSM states: IDLE, WR, RD; mem_req = (state != IDLE), mem_we = (state == WR), both registered.
REQ-022 IDLE -> WR when buffer non-empty; IDLE -> RD when read pending and buffer empty.
REQ-023 WR, ack: pop head; -> WR if entries remain after pop, else RD if read pending, else IDLE.
REQ-024 RD, ack: rd_reg <= data, rd_valid <= 1, pending cleared, -> WR if non-empty, else IDLE.
REQ-025 No timeout: WR and RD SHALL hold mem_req until ack.
REQ-026 Writes before a read SHALL complete first (read-after-write ordering); pushes arriving during RD wait for RD completion.
REQ-027 nLr accepted only when no read pending and state != RD; on accept: pending <= 1, rd_valid <= 0. Otherwise ignored.
REQ-028 nLw and nLr in the same cycle: push accepted; read served after that word is written.
REQ-029 Latency: push at edge N with idle FSM -> mem_req = 1 after edge N+1; single-cycle ack allowed.
REQ-030 rd_reg SHALL hold its value until the next completed read.

Reset
REQ-031 nCLR low SHALL immediately force: state IDLE, mem_req 0, mem_we 0, count 0, pointers 0, empty 1, full 0, rd_reg 0, rd_valid 0, pending 0, ovf 0.
REQ-032 Reset during a WR/RD SHALL abandon the transaction; no pop, no rd_reg update.
REQ-033 After nCLR deasserts, the first push SHALL be accepted at the next posedge.

Structure
REQ-034 Shared package SHALL hold FSM state encoding (IDLE = 0, WR = 1, RD = 2) and WIDTH/DEPTH defaults.
REQ-035 Storage SHALL be one sub-module, mdr_fifo_buf (parametrised synchronous FIFO with count, full, empty); FSM and tristate drivers in the top level.

Verification
REQ-036 Reset, Ew = 1 -> WBUS = 0x00, empty = 1, mem_req = 0, rd_valid = 0.
REQ-037 Push 0x25, ack one cycle after mem_req -> data = 0x25 with mem_we = 1, then empty = 1, state IDLE.
REQ-038 Push 0x11, 0x22, 0x33, 0x44, 0x55 with ack held low -> full after the 4th, ovf = 1, memory later sees 0x11..0x44 in order.
REQ-039 Push 0x35 and nLr in the same cycle, memory returns 0x37 -> write 0x35 completes before the read; rd_valid = 1; Ew = 1 gives WBUS = 0x37.
REQ-040 nCLR pulsed low mid-WR with 2 entries -> mem_req drops asynchronously, empty = 1, no further memory writes.
REQ-041 DEPTH = 2, WIDTH = 16: 6 push/ack cycles with simultaneous push and pop -> pointer wrap, count stays within 0..2, data 0xBEEF preserved.
